aes_sub_sched: RTL and testbench
================================

AES_SUB_SCHED -- requirements
Module: aes_sub_sched

Interface
REQ-001 SHALL have parameter SBOX_BYTES, default 4: bytes substituted per cycle by the shared S-box; legal values are 4, 8 and 16.
REQ-002 SHALL have a derived constant P = 16/SBOX_BYTES, the number of passes per 128-bit request.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Ports, in order:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- dp_req_valid / dp_req_ready, input / output, 1: SubBytes request handshake.
- dp_req_data, input, 128: state to substitute.
- dp_rsp_valid / dp_rsp_ready, output / input, 1: SubBytes response handshake.
- dp_rsp_data, output, 128: substituted state.
- ks_req_valid / ks_req_ready, input / output, 1: SubWord request handshake from key expansion.
- ks_req_data, input, 32: word to substitute.
- ks_rsp_valid / ks_rsp_ready, output / input, 1: SubWord response handshake.
- ks_rsp_data, output, 32: substituted word.
- sbox_in, output, SBOX_BYTES*8: drives the external combinational S-box instance (NUM=SBOX_BYTES).
- sbox_out, input, SBOX_BYTES*8: result from that instance.

Function
REQ-005 SHALL implement FSM states IDLE, DP_BUSY, DP_RSP, KS_BUSY and KS_RSP.
REQ-006 SHALL accept a request only in IDLE. A transfer occurs on a rising edge where valid and ready are both high. At most one ready is high in any cycle.
REQ-007 Arbitration in IDLE:
- Only one valid high: that requester gets ready.
- Both valid high: round-robin; the requester not granted last gets ready.
- The last-grant flag resets to DP, so KS wins the first tie after reset.
REQ-008 On accept, the FSM SHALL capture request data into an internal register; later changes on req_data have no effect.
REQ-009 DP_BUSY:
- A pass counter runs 0..P-1, one pass per cycle.
- sbox_in = captured bytes [k*SBOX_BYTES*8 +: SBOX_BYTES*8] for pass k; pass 0 covers the least-significant bytes.
- sbox_out is written into the same slice of the result register on each edge.
- After pass P-1 the FSM goes to DP_RSP.
REQ-010 KS_BUSY lasts exactly one cycle:
- sbox_in low 32 bits = captured word; upper bits = 0.
- Result low 32 bits are captured; the FSM then goes to KS_RSP.
REQ-011 Latency: rsp_valid SHALL rise after the P-th (DP) or 1st (KS) rising edge following the accepting edge.
REQ-012 In DP_RSP/KS_RSP, rsp_valid SHALL be high and rsp_data stable until the edge where rsp_ready is high; the FSM then returns to IDLE. No new request is accepted in that same cycle.
REQ-013 sbox_in SHALL be zero in IDLE, DP_RSP and KS_RSP.
REQ-014 dp_rsp_data and ks_rsp_data SHALL hold their last result when not valid. ks_rsp_data = sbox_out[31:0] as captured.

Reset
REQ-015 Asserting rst_n low, including mid-operation, SHALL immediately force:
- FSM to IDLE, pass counter to 0, last-grant flag to DP.
- All req_ready and rsp_valid low.
- dp_rsp_data, ks_rsp_data and sbox_in to 0.
- Any in-flight request discarded.
REQ-016 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-017 With macro AES_SUB_SCHED_STATS_EN defined, the block SHALL add outputs dp_grant_cnt[15:0] and ks_grant_cnt[15:0]:
- Each increments on its accept edge.
- Each saturates at 16'hFFFF.
- Each resets to 0.
REQ-018 Without AES_SUB_SCHED_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-019 KS single request: ks_req_data=32'h0000_4F00, rsp_ready=1 -> ks_rsp_data=32'h6363_8463 one edge after accept; ks_rsp_valid high for 1 cycle.
REQ-020 DP request, SBOX_BYTES=4: dp_req_data=128'h0 -> dp_rsp_data=all bytes 8'h63, dp_rsp_valid rising 4 edges after accept.
REQ-021 Simultaneous dp/ks valid right after reset -> KS granted first, DP second. A second simultaneous pair -> KS granted again, since DP was last granted.
REQ-022 Backpressure: DP low word 32'hFF80_2F8D with dp_rsp_ready low for 3 cycles -> dp_rsp_data[31:0]=32'h16CD_155D held stable; ks_req_ready stays low throughout.
REQ-023 rst_n low during DP pass 2 -> dp_rsp_valid never asserts; all outputs 0. A fresh KS request afterwards completes normally.
REQ-024 With AES_SUB_SCHED_STATS_EN, 3 DP and 2 KS transactions -> dp_grant_cnt=3 and ks_grant_cnt=2.

Source files
------------

// File: rtl/aes_sub_sched.sv
// Time-shares one external SBOX_BYTES-wide S-box between datapath SubBytes and key-schedule SubWord.
// Optional grant counters are compiled in with `define AES_SUB_SCHED_STATS_EN.
module aes_sub_sched #(
    parameter int unsigned SBOX_BYTES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dp_req_valid,
    output logic                      dp_req_ready,
    input  logic [127:0]              dp_req_data,
    output logic                      dp_rsp_valid,
    input  logic                      dp_rsp_ready,
    output logic [127:0]              dp_rsp_data,
    input  logic                      ks_req_valid,
    output logic                      ks_req_ready,
    input  logic [31:0]               ks_req_data,
    output logic                      ks_rsp_valid,
    input  logic                      ks_rsp_ready,
    output logic [31:0]               ks_rsp_data,
    output logic [SBOX_BYTES*8-1:0]   sbox_in,
    input  logic [SBOX_BYTES*8-1:0]   sbox_out
`ifdef AES_SUB_SCHED_STATS_EN
    ,
    output logic [15:0]               dp_grant_cnt,
    output logic [15:0]               ks_grant_cnt
`endif
);

    localparam int unsigned SW = SBOX_BYTES * 8;
    localparam int unsigned P  = 16 / SBOX_BYTES;
    localparam int unsigned CW = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DP_BUSY = 3'd1,
        DP_RSP  = 3'd2,
        KS_BUSY = 3'd3,
        KS_RSP  = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   pass_q;
    logic            last_ks_q;
    logic [127:0]    cap_q;
    logic [127:0]    cap_upd;
    logic            last_pass;
    logic            dp_acc;
    logic            ks_acc;
    int unsigned     pass_idx;
    int unsigned     next_idx;

    assign pass_idx  = 32'(pass_q);
    assign next_idx  = pass_idx + 32'd1;
    assign last_pass = (pass_q == CW'(P - 1));
    assign dp_acc    = dp_req_valid && dp_req_ready;
    assign ks_acc    = ks_req_valid && ks_req_ready;

    // Captured state with the current pass's slice already substituted; consumed slices are reused.
    always_comb begin
        cap_upd = cap_q;
        cap_upd[pass_idx*SW +: SW] = sbox_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and round-robin grant; readies are gated by reset so none shows while held.
    always_comb begin
        state_d      = state_q;
        dp_req_ready = 1'b0;
        ks_req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n) begin
                    if (dp_req_valid && (!ks_req_valid || last_ks_q)) begin
                        dp_req_ready = 1'b1;
                        state_d      = DP_BUSY;
                    end else if (ks_req_valid) begin
                        ks_req_ready = 1'b1;
                        state_d      = KS_BUSY;
                    end
                end
            end
            DP_BUSY: begin
                if (last_pass) begin
                    state_d = DP_RSP;
                end
            end
            DP_RSP: begin
                if (dp_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            KS_BUSY: state_d = KS_RSP;
            KS_RSP: begin
                if (ks_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: sbox_in is preloaded one edge ahead so each pass sees its slice for a full cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q       <= '0;
            last_ks_q    <= 1'b0;
            cap_q        <= '0;
            dp_rsp_data  <= '0;
            ks_rsp_data  <= '0;
            sbox_in      <= '0;
            dp_rsp_valid <= 1'b0;
            ks_rsp_valid <= 1'b0;
        end else begin
            dp_rsp_valid <= (state_d == DP_RSP);
            ks_rsp_valid <= (state_d == KS_RSP);
            sbox_in      <= '0;
            if (dp_acc) begin
                cap_q     <= dp_req_data;
                sbox_in   <= dp_req_data[SW-1:0];
                pass_q    <= '0;
                last_ks_q <= 1'b0;
            end
            if (ks_acc) begin
                sbox_in   <= SW'(ks_req_data);
                last_ks_q <= 1'b1;
            end
            if (state_q == DP_BUSY) begin
                cap_q <= cap_upd;
                if (last_pass) begin
                    dp_rsp_data <= cap_upd;
                    pass_q      <= '0;
                end else begin
                    pass_q  <= pass_q + CW'(1);
                    sbox_in <= cap_q[next_idx*SW +: SW];
                end
            end
            if (state_q == KS_BUSY) begin
                ks_rsp_data <= sbox_out[31:0];
            end
        end
    end

`ifdef AES_SUB_SCHED_STATS_EN
    // Saturating accept counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_grant_cnt <= '0;
            ks_grant_cnt <= '0;
        end else begin
            if (dp_acc && (dp_grant_cnt != 16'hFFFF)) begin
                dp_grant_cnt <= dp_grant_cnt + 16'd1;
            end
            if (ks_acc && (ks_grant_cnt != 16'hFFFF)) begin
                ks_grant_cnt <= ks_grant_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_sub_sched.sv
// Self-checking bench for aes_sub_sched; the external S-box and the reference model are
// both derived from GF(2^8) inversion plus the AES affine map.
module tb_aes_sub_sched;

    localparam int SB = 4;
    localparam int P  = 16 / SB;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            dp_req_valid, dp_req_ready;
    logic [127:0]    dp_req_data;
    logic            dp_rsp_valid, dp_rsp_ready;
    logic [127:0]    dp_rsp_data;
    logic            ks_req_valid, ks_req_ready;
    logic [31:0]     ks_req_data;
    logic            ks_rsp_valid, ks_rsp_ready;
    logic [31:0]     ks_rsp_data;
    logic [SB*8-1:0] sbox_in;
    logic [SB*8-1:0] sbox_out;
`ifdef AES_SUB_SCHED_STATS_EN
    logic [15:0]     dp_grant_cnt, ks_grant_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    aes_sub_sched #(.SBOX_BYTES(SB)) dut (
        .clk(clk), .rst_n(rst_n),
        .dp_req_valid(dp_req_valid), .dp_req_ready(dp_req_ready), .dp_req_data(dp_req_data),
        .dp_rsp_valid(dp_rsp_valid), .dp_rsp_ready(dp_rsp_ready), .dp_rsp_data(dp_rsp_data),
        .ks_req_valid(ks_req_valid), .ks_req_ready(ks_req_ready), .ks_req_data(ks_req_data),
        .ks_rsp_valid(ks_rsp_valid), .ks_rsp_ready(ks_rsp_ready), .ks_rsp_data(ks_rsp_data),
        .sbox_in(sbox_in), .sbox_out(sbox_out)
`ifdef AES_SUB_SCHED_STATS_EN
        , .dp_grant_cnt(dp_grant_cnt), .ks_grant_cnt(ks_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(a, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox_f(d[i*8 +: 8]);
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = sbox_f(w[i*8 +: 8]);
        return r;
    endfunction

    // External combinational S-box instance
    always_comb begin
        sbox_out = '0;
        for (int i = 0; i < SB; i++) sbox_out[i*8 +: 8] = sbox_f(sbox_in[i*8 +: 8]);
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        dp_req_valid = 1'b0; ks_req_valid = 1'b0;
        dp_rsp_ready = 1'b0; ks_rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_dp(input logic [127:0] d, input int stall, output logic [127:0] got,
                         output int lat, output bit ok, output bit lingered);
        int cyc;
        ok = 1'b1; lat = 0; got = '0; lingered = 1'b0;
        @(negedge clk);
        dp_req_valid = 1'b1; dp_req_data = d;
        #1;
        cyc = 0;
        while (!dp_req_ready && cyc < 50) begin @(negedge clk); #1; cyc++; end
        if (!dp_req_ready) begin dp_req_valid = 1'b0; ok = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        dp_req_valid = 1'b0; dp_req_data = {4{$urandom()}};
        cyc = 0;
        while (!dp_rsp_valid && cyc < 50) begin @(negedge clk); cyc++; end
        lat = cyc;
        if (!dp_rsp_valid) begin ok = 1'b0; return; end
        repeat (stall) @(negedge clk);
        got = dp_rsp_data;
        dp_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dp_rsp_ready = 1'b0;
        lingered = dp_rsp_valid;
    endtask

    task automatic do_ks(input logic [31:0] w, input int stall, output logic [31:0] got,
                         output int lat, output bit ok, output bit lingered);
        int cyc;
        ok = 1'b1; lat = 0; got = '0; lingered = 1'b0;
        @(negedge clk);
        ks_req_valid = 1'b1; ks_req_data = w;
        #1;
        cyc = 0;
        while (!ks_req_ready && cyc < 50) begin @(negedge clk); #1; cyc++; end
        if (!ks_req_ready) begin ks_req_valid = 1'b0; ok = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        ks_req_valid = 1'b0; ks_req_data = $urandom();
        cyc = 0;
        while (!ks_rsp_valid && cyc < 50) begin @(negedge clk); cyc++; end
        lat = cyc;
        if (!ks_rsp_valid) begin ok = 1'b0; return; end
        repeat (stall) @(negedge clk);
        got = ks_rsp_data;
        ks_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ks_rsp_ready = 1'b0;
        lingered = ks_rsp_valid;
    endtask

    task automatic test_reset();
        logic [31:0] got; int lat; bit ok, lng;
        logic [31:0] w;
        rst_n = 1'b0;
        dp_req_valid = 1'b1; ks_req_valid = 1'b1;
        dp_req_data = '0; ks_req_data = 32'h0;
        dp_rsp_ready = 1'b0; ks_rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({dp_req_ready, ks_req_ready, dp_rsp_valid, ks_rsp_valid} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_handshake: got %b required 0000",
                     {dp_req_ready, ks_req_ready, dp_rsp_valid, ks_rsp_valid});
        end
        tests_run++;
        if ({dp_rsp_data, ks_rsp_data, sbox_in} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: dp %h ks %h sbox_in %h required 0", dp_rsp_data, ks_rsp_data, sbox_in);
        end
        // First accept on the first edge after release
        dp_req_valid = 1'b0;
        w = $urandom();
        ks_req_data = w;
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (ks_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_first_accept: ks_req_ready %b required 1", ks_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        ks_req_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ks_rsp_valid !== 1'b1 || ks_rsp_data !== sub_word(w)) begin
            tests_failed++;
            $display("FAIL reset_first_rsp: valid %b data %h required 1 %h", ks_rsp_valid, ks_rsp_data, sub_word(w));
        end
        ks_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ks_rsp_ready = 1'b0;
        got = '0; lat = 0; ok = 1'b1; lng = 1'b0;
    endtask

    task automatic test_ks_single();
        logic [31:0] got; int lat; bit ok, lng;
        ks_rsp_ready = 1'b1;
        do_ks(32'h0000_4F00, 0, got, lat, ok, lng);
        tests_run++;
        if (!ok || got !== 32'h6363_8463 || lat !== 1 || lng !== 1'b0) begin
            tests_failed++;
            $display("FAIL ks_single: ok %0d data %h lat %0d lingered %0d required 1 63638463 1 0", ok, got, lat, lng);
        end
        tests_run++;
        if (sbox_in !== '0) begin
            tests_failed++;
            $display("FAIL ks_idle_sbox: sbox_in %h required 0", sbox_in);
        end
    endtask

    task automatic test_dp_zero();
        logic [127:0] got; int lat; bit ok, lng;
        do_dp(128'h0, 0, got, lat, ok, lng);
        tests_run++;
        if (!ok || got !== {16{8'h63}} || lat !== P) begin
            tests_failed++;
            $display("FAIL dp_zero: ok %0d data %h lat %0d required 1 all-63 %0d", ok, got, lat, P);
        end
    endtask

    task automatic test_tie();
        logic [127:0] d; logic [31:0] w; int cyc;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            w = $urandom();
            @(negedge clk);
            dp_req_valid = 1'b1; dp_req_data = d;
            ks_req_valid = 1'b1; ks_req_data = w;
            #1;
            tests_run++;
            if (ks_req_ready !== 1'b1 || dp_req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL tie_ks_first round %0d: ks %b dp %b required 1 0", r, ks_req_ready, dp_req_ready);
            end
            @(posedge clk);
            @(negedge clk);
            ks_req_valid = 1'b0;
            cyc = 0;
            while (!ks_rsp_valid && cyc < 50) begin @(negedge clk); cyc++; end
            tests_run++;
            if (ks_rsp_valid !== 1'b1 || ks_rsp_data !== sub_word(w)) begin
                tests_failed++;
                $display("FAIL tie_ks_data round %0d: valid %b data %h required 1 %h", r, ks_rsp_valid, ks_rsp_data, sub_word(w));
            end
            ks_rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ks_rsp_ready = 1'b0;
            #1;
            tests_run++;
            if (dp_req_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL tie_dp_second round %0d: dp_req_ready %b required 1", r, dp_req_ready);
            end
            @(posedge clk);
            @(negedge clk);
            dp_req_valid = 1'b0;
            cyc = 0;
            while (!dp_rsp_valid && cyc < 50) begin @(negedge clk); cyc++; end
            tests_run++;
            if (dp_rsp_valid !== 1'b1 || dp_rsp_data !== sub_bytes(d)) begin
                tests_failed++;
                $display("FAIL tie_dp_data round %0d: valid %b data %h required 1 %h", r, dp_rsp_valid, dp_rsp_data, sub_bytes(d));
            end
            dp_rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            dp_rsp_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d, exp; logic [31:0] w; int cyc; bit ks_seen;
        d = {$urandom(), $urandom(), $urandom(), 32'hFF80_2F8D};
        exp = sub_bytes(d);
        w = $urandom();
        @(negedge clk);
        dp_req_valid = 1'b1; dp_req_data = d;
        #1;
        tests_run++;
        if (dp_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_accept: dp_req_ready %b required 1", dp_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        dp_req_valid = 1'b0;
        ks_req_valid = 1'b1; ks_req_data = w;
        #1;
        ks_seen = ks_req_ready;
        cyc = 0;
        while (!dp_rsp_valid && cyc < 50) begin @(negedge clk); ks_seen |= ks_req_ready; cyc++; end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (dp_rsp_valid !== 1'b1 || dp_rsp_data[31:0] !== 32'h16CD_155D || dp_rsp_data !== exp
                || ks_req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold cycle %0d: valid %b data %h ks_ready %b required 1 %h 0",
                         i, dp_rsp_valid, dp_rsp_data, ks_req_ready, exp);
            end
            @(negedge clk);
            ks_seen |= ks_req_ready;
        end
        tests_run++;
        if (ks_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_ks_blocked: ks_req_ready seen %b required 0", ks_seen);
        end
        dp_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dp_rsp_ready = 1'b0;
        #1;
        tests_run++;
        if (ks_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_ks_after: ks_req_ready %b required 1", ks_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        ks_req_valid = 1'b0;
        cyc = 0;
        while (!ks_rsp_valid && cyc < 50) begin @(negedge clk); cyc++; end
        tests_run++;
        if (ks_rsp_valid !== 1'b1 || ks_rsp_data !== sub_word(w)) begin
            tests_failed++;
            $display("FAIL bp_ks_data: valid %b data %h required 1 %h", ks_rsp_valid, ks_rsp_data, sub_word(w));
        end
        ks_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ks_rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] d; logic [31:0] w, got; int lat; bit ok, lng, seen;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        w = $urandom();
        @(negedge clk);
        dp_req_valid = 1'b1; dp_req_data = d;
        #1;
        tests_run++;
        if (dp_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_accept: dp_req_ready %b required 1", dp_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        dp_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (sbox_in !== d[2*SB*8 +: SB*8]) begin
            tests_failed++;
            $display("FAIL mid_pass2_sbox_in: got %h required %h", sbox_in, d[2*SB*8 +: SB*8]);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({dp_req_ready, ks_req_ready, dp_rsp_valid, ks_rsp_valid, dp_rsp_data, ks_rsp_data, sbox_in} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: dp %h ks %h sbox_in %h flags %b required all 0", dp_rsp_data,
                     ks_rsp_data, sbox_in, {dp_req_ready, ks_req_ready, dp_rsp_valid, ks_rsp_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); seen |= dp_rsp_valid; end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_no_rsp: dp_rsp_valid seen %b required 0", seen);
        end
        do_ks(w, 1, got, lat, ok, lng);
        tests_run++;
        if (!ok || got !== sub_word(w) || lat !== 1) begin
            tests_failed++;
            $display("FAIL mid_ks_after: ok %0d data %h lat %0d required 1 %h 1", ok, got, lat, sub_word(w));
        end
    endtask

    task automatic test_random();
        logic [127:0] d, gd; logic [31:0] w, gw; int lat, stall; bit ok, lng;
        for (int i = 0; i < 24; i++) begin
            stall = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) begin
                d = {$urandom(), $urandom(), $urandom(), $urandom()};
                do_dp(d, stall, gd, lat, ok, lng);
                tests_run++;
                if (!ok || gd !== sub_bytes(d) || lat !== P || lng !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rand_dp %0d: ok %0d data %h lat %0d lingered %0d required 1 %h %0d 0",
                             i, ok, gd, lat, lng, sub_bytes(d), P);
                end
            end else begin
                w = $urandom();
                do_ks(w, stall, gw, lat, ok, lng);
                tests_run++;
                if (!ok || gw !== sub_word(w) || lat !== 1 || lng !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rand_ks %0d: ok %0d data %h lat %0d lingered %0d required 1 %h 1 0",
                             i, ok, gw, lat, lng, sub_word(w));
                end
            end
            tests_run++;
            if (sbox_in !== '0) begin
                tests_failed++;
                $display("FAIL rand_idle_sbox %0d: sbox_in %h required 0", i, sbox_in);
            end
        end
    endtask

`ifdef AES_SUB_SCHED_STATS_EN
    task automatic test_stats();
        logic [127:0] gd; logic [31:0] gw; int lat; bit ok, lng;
        apply_reset();
        tests_run++;
        if (dp_grant_cnt !== 16'd0 || ks_grant_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL stats_reset: dp %0d ks %0d required 0 0", dp_grant_cnt, ks_grant_cnt);
        end
        for (int i = 0; i < 3; i++) do_dp({4{$urandom()}}, 0, gd, lat, ok, lng);
        for (int i = 0; i < 2; i++) do_ks($urandom(), 0, gw, lat, ok, lng);
        tests_run++;
        if (dp_grant_cnt !== 16'd3 || ks_grant_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL stats_count: dp %0d ks %0d required 3 2", dp_grant_cnt, ks_grant_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ks_single();
        test_dp_zero();
        test_tie();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef AES_SUB_SCHED_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
